// File: rtl/retospect_lif_cnb.sv
// retospect_lif_cnb: serially configured leaky integrate-and-fire neuron with a daisy-chainable config shift register.
module retospect_lif_cnb #(
    parameter int N_IN     = 4,
    parameter int W_BITS   = 3,
    parameter int UT_BITS  = 4,
    parameter int DEC_BITS = 3,
    parameter int ACC_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       preset,
    input  logic                       config_en,
    input  logic                       bs_in,
    output logic                       bs_out,
    input  logic [N_IN-1:0]            spike_in,
    output logic                       spike_out,
    output logic signed [ACC_BITS-1:0] membrane
);
    localparam int L  = N_IN * W_BITS + UT_BITS + DEC_BITS;
    localparam int SW = ACC_BITS + $clog2(N_IN) + 1;
    localparam int PW = (1 << DEC_BITS) - 1;
    localparam logic signed [SW-1:0] HI = SW'((2 ** (ACC_BITS - 1)) - 1);
    localparam logic signed [SW-1:0] LO = -HI - SW'(1);

    // w[0] sits at the top of the chain, decay_sel at the bottom feeding bs_out
    logic [L-1:0]                ch;
    logic [PW-1:0]               pre, pmax;
    logic signed [ACC_BITS-1:0]  acc;
    logic [UT_BITS-1:0]          ut;
    logic [DEC_BITS-1:0]         ds;
    logic signed [SW-1:0]        syn, ae, lk, sum;
    logic [ACC_BITS-1:0]         nxt;
    logic                        dis, tick, fire;

    assign ut       = ch[DEC_BITS +: UT_BITS];
    assign ds       = ch[DEC_BITS-1:0];
    assign bs_out   = ch[0];
    assign membrane = acc;

    always_comb begin
        syn = '0;
        for (int i = 0; i < N_IN; i++)
            if (spike_in[i])
                syn = syn + {{(SW-W_BITS){ch[L-1-i*W_BITS]}}, ch[L-1-i*W_BITS -: W_BITS]};
        dis  = &ds;
        pmax = (PW'(1) << ds) - PW'(1);
        tick = !dis && (pre == pmax);
        ae   = {{(SW-ACC_BITS){acc[ACC_BITS-1]}}, acc};
        lk   = (tick && acc > 0) ? ae - SW'(1) : (tick && acc < 0) ? ae + SW'(1) : ae;
        sum  = lk + syn;
        nxt  = sum > HI ? HI[ACC_BITS-1:0] : sum < LO ? LO[ACC_BITS-1:0] : sum[ACC_BITS-1:0];
        fire = !nxt[ACC_BITS-1] && (nxt >= {{(ACC_BITS-UT_BITS){1'b0}}, ut});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch        <= '0;
            acc       <= '0;
            pre       <= '0;
            spike_out <= 1'b0;
        end else if (preset) begin
            ch[DEC_BITS +: UT_BITS] <= UT_BITS'(1);
            acc       <= '0;
            pre       <= '0;
            spike_out <= 1'b0;
        end else if (config_en) begin
            ch        <= {bs_in, ch[L-1:1]};
            acc       <= '0;
            pre       <= '0;
            spike_out <= 1'b0;
        end else begin
            spike_out <= fire;
            acc       <= fire ? '0 : nxt;
            pre       <= (dis || tick) ? '0 : pre + PW'(1);
        end
    end
endmodule

// File: tb/tb_retospect_lif_cnb.sv
// tb_retospect_lif_cnb: directed vector bench for the LIF neuron block.
module tb_retospect_lif_cnb;
    logic clk = 1'b0;
    logic reset = 1'b0, preset = 1'b0, config_en = 1'b0, bs_in = 1'b0;
    logic [3:0] spike_in = '0;
    logic bs_out, spike_out;
    logic signed [7:0] membrane;
    int checks = 0, errors = 0;

    typedef struct {
        logic              cfg_now;
        logic [18:0]       cfg;
        logic [3:0]        sp;
        logic              spk;
        logic signed [7:0] mem;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    retospect_lif_cnb dut (
        .clk(clk), .reset(reset), .preset(preset), .config_en(config_en),
        .bs_in(bs_in), .bs_out(bs_out), .spike_in(spike_in),
        .spike_out(spike_out), .membrane(membrane)
    );

    function automatic logic [18:0] mk(logic [2:0] a, logic [2:0] b, logic [2:0] c,
                                       logic [2:0] d, logic [3:0] u, logic [2:0] s);
        return {a, b, c, d, u, s};
    endfunction

    task automatic chk(string n, logic signed [31:0] act, logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic step(logic r, logic p, logic c, logic b, logic [3:0] sp);
        reset = r; preset = p; config_en = c; bs_in = b; spike_in = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic load(logic [18:0] v);
        for (int i = 0; i < 19; i++) step(0, 0, 1, v[i], 4'b0);
    endtask

    task automatic add(logic c, logic [18:0] v, logic [3:0] sp, logic spk, logic signed [7:0] mem);
        vec_t t;
        t.cfg_now = c; t.cfg = v; t.sp = sp; t.spk = spk; t.mem = mem;
        vecs.push_back(t);
    endtask

    initial begin
        logic [18:0] pat, exp;
        logic signed [7:0] m;
        // integrate to threshold, fire, reset
        add(1, mk(3'd3, 0, 0, 0, 4'd7, 3'd7), 4'b0001, 0, 8'sd3);
        add(0, '0, 4'b0001, 0, 8'sd6);
        add(0, '0, 4'b0001, 1, 8'sd0);
        add(0, '0, 4'b0000, 0, 8'sd0);
        // leak every second cycle down to zero
        add(1, mk(3'd2, 0, 0, 0, 4'd15, 3'd1), 4'b0001, 0, 8'sd2);
        add(0, '0, 4'b0000, 0, 8'sd1);
        add(0, '0, 4'b0000, 0, 8'sd1);
        add(0, '0, 4'b0000, 0, 8'sd0);
        add(0, '0, 4'b0000, 0, 8'sd0);
        add(0, '0, 4'b0000, 0, 8'sd0);
        // negative leak every cycle toward zero
        add(1, mk(3'b101, 0, 0, 0, 4'd15, 3'd0), 4'b0001, 0, -8'sd3);
        add(0, '0, 4'b0000, 0, -8'sd2);
        add(0, '0, 4'b0000, 0, -8'sd1);
        add(0, '0, 4'b0000, 0, 8'sd0);
        add(0, '0, 4'b0000, 0, 8'sd0);
        // mixed-sign weights
        add(1, mk(3'b011, 3'b110, 3'b001, 3'b111, 4'd15, 3'd7), 4'b0101, 0, 8'sd4);
        add(0, '0, 4'b1010, 0, 8'sd1);
        add(0, '0, 4'b1111, 0, 8'sd2);
        add(0, '0, 4'b0011, 0, 8'sd3);
        // uT = 0 fires every cycle
        add(1, mk(0, 0, 0, 0, 4'd0, 3'd7), 4'b0000, 1, 8'sd0);
        add(0, '0, 4'b0000, 1, 8'sd0);
        // negative saturation
        for (int i = 0; i < 40; i++) begin
            m = (i < 7) ? 8'(-16 * (i + 1)) : -8'sd128;
            add(i == 0, mk(3'b100, 3'b100, 3'b100, 3'b100, 4'd15, 3'd7), 4'b1111, 0, m);
        end

        step(1, 0, 0, 0, 4'b0);
        chk("rst_bs", bs_out, 0);
        chk("rst_spk", spike_out, 0);
        chk("rst_mem", membrane, 0);

        pat = 19'h5A5A5;
        load(pat);
        chk("cfg_mem", membrane, 0);
        for (int j = 0; j < 19; j++) begin
            chk($sformatf("readout[%0d]", j), bs_out, pat[j]);
            step(0, 0, 1, 0, 4'b0);
        end
        chk("readout_empty", bs_out, 0);

        foreach (vecs[k]) begin
            if (vecs[k].cfg_now) load(vecs[k].cfg);
            step(0, 0, 0, 0, vecs[k].sp);
            chk($sformatf("v%0d_spk", k), spike_out, vecs[k].spk);
            chk($sformatf("v%0d_mem", k), membrane, vecs[k].mem);
        end

        // preset restores threshold 1
        step(1, 0, 0, 0, 4'b0);
        load(mk(3'd1, 0, 0, 0, 4'd15, 3'd7));
        step(0, 1, 0, 0, 4'b0);
        chk("preset_spk", spike_out, 0);
        chk("preset_mem", membrane, 0);
        step(0, 0, 0, 0, 4'b0);
        chk("preset_idle_spk", spike_out, 0);
        chk("preset_idle_mem", membrane, 0);
        step(0, 0, 0, 0, 4'b0001);
        chk("preset_fire_spk", spike_out, 1);
        chk("preset_fire_mem", membrane, 0);
        step(0, 0, 0, 0, 4'b0000);
        chk("preset_one_shot", spike_out, 0);

        // reset wins over config_en mid-shift
        load(mk(3'd3, 0, 0, 0, 4'd5, 3'd7));
        chk("pre_rst_bs", bs_out, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 4'b0);
        step(1, 0, 1, 1, 4'b1111);
        chk("rst_cfg_bs", bs_out, 0);
        chk("rst_cfg_mem", membrane, 0);
        chk("rst_cfg_spk", spike_out, 0);
        for (int j = 0; j < 19; j++) begin
            chk($sformatf("rst_clear[%0d]", j), bs_out, 0);
            step(0, 0, 1, 0, 4'b0);
        end

        // preset wins over config_en: uT set, no shift
        load(mk(3'd3, 0, 0, 0, 4'd0, 3'd5));
        step(0, 1, 1, 0, 4'b0);
        exp = mk(3'd3, 0, 0, 0, 4'd1, 3'd5);
        for (int j = 0; j < 19; j++) begin
            chk($sformatf("preset_cfg[%0d]", j), bs_out, exp[j]);
            step(0, 0, 1, 0, 4'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/retospect_lif_cnb.md
Name: retospect_lif_cnb

Overview:
- Parametrised successor of the configurable neuron block: same serial config chain, plus a working leaky integrate-and-fire datapath.
- N_IN signed synaptic weights, an unsigned threshold and a decay-rate select are shifted in over one bit-serial chain.
- In run mode the block integrates weighted input spikes, leaks toward zero and emits one-cycle output spikes.
- Instances tile the neurochip array, daisy-chained bs_out to bs_in, with spike_in/spike_out wired through the array fabric.

Parameters:
- N_IN, 4, number of synaptic inputs
- W_BITS, 3, width of each weight, signed two's complement
- UT_BITS, 4, threshold width, unsigned
- DEC_BITS, 3, decay-select width
- ACC_BITS, 8, membrane accumulator width, signed

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- preset  in  1  synchronous; loads default threshold
- config_en  in  1  1 = shift config chain, 0 = run
- bs_in  in  1  serial config input
- bs_out  out  1  serial config output = decay_sel[0] (registered bit, no comb path from bs_in)
- spike_in  in  N_IN  input spikes, bit i gates weight i
- spike_out  out  1  registered output spike
- membrane  out  ACC_BITS  current accumulator value (debug/observe)

Behaviour:
- Chain length L = N_IN*W_BITS + UT_BITS + DEC_BITS (19 at defaults).
- Shift order: bs_in -> w[0] MSB ... w[0] LSB -> w[1] MSB ... -> w[N_IN-1] LSB -> uT MSB ... uT LSB -> decay_sel MSB ... LSB -> bs_out.
- Each register shifts right by one per config cycle.
- Priority per edge: reset > preset > config_en > run.
- reset: all weights, uT, decay_sel, acc, prescaler and spike_out = 0; bs_out = 0.
- preset: uT <= 1, acc <= 0, prescaler <= 0, spike_out <= 0; weights and decay_sel unchanged.
- config_en=1: chain shifts one bit; acc, prescaler and spike_out forced to 0; spike_in ignored.
- Run (config_en=0), per cycle:
  - syn = sum of sign-extended w[i] over bits i with spike_in[i]=1. Computed at ACC_BITS+clog2(N_IN)+1 bits, no overflow.
  - decay_tick: prescaler counts 0 .. 2^decay_sel - 1 and wraps; tick asserts in the wrap cycle.
  - decay_sel all-ones means decay disabled; prescaler held at 0.
  - leaked = acc - 1 if tick and acc > 0; acc + 1 if tick and acc < 0; otherwise acc.
  - nxt = saturate(leaked + syn) to [-2^(ACC_BITS-1), 2^(ACC_BITS-1) - 1].
  - If nxt >= 0 and nxt >= uT (unsigned compare): spike_out <= 1 and acc <= 0. Otherwise spike_out <= 0 and acc <= nxt.
  - Latency: spike_in sampled at edge k gives spike_out high after edge k; spike_out is high for exactly one cycle per fire.
  - uT = 0: fires every run cycle while nxt >= 0 ("always firing").
- config_en dropping to 0 mid-chain: partial configuration stays in effect; run starts from acc = 0.
- reset or preset in any mode takes effect on the same edge.

Test Plan:
- Reset, then 19 config cycles shifting 0x5A5A5 pattern with config_en=1; run 19 more config cycles with bs_in=0 -> bs_out reproduces the first 19 bits in order, and registers read back as loaded.
- Config w0=+3, others 0, uT=7, decay_sel=7; spike_in=0001 for 3 cycles -> acc 3, 6, then spike_out=1 on cycle 3 (9 >= 7) with acc=0.
- Config w0=+2, uT=15, decay_sel=1; one spike then idle -> acc=2, then decrements by 1 every 2 cycles to 0 and holds at 0.
- Config w0=w1=w2=w3=-4, uT=15; spike_in=1111 for 40 cycles -> acc saturates at -128, no spike, no wrap.
- After reset, pulse preset with spike_in=0 -> uT=1, next run cycle acc=0 < 1, no spike; one +1 spike -> spike_out=1 next cycle.
- Assert reset and config_en together mid-shift -> all state 0, bs_out=0; preset with config_en=1 -> uT=1, no shift that cycle.
